// File: rtl/dmem_pkg.sv
// Shared definitions for the parametrised data memory: FSM state encoding and
// the access-width codes carried in sign_mask[2:0].
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_BUFFER = 2'd1,
    READ        = 2'd2,
    WRITE       = 2'd3
  } dmem_state_t;

  localparam logic [2:0] SM_BYTE = 3'b001;
  localparam logic [2:0] SM_HALF = 3'b011;
  localparam logic [2:0] SM_WORD = 3'b111;

endpackage

// File: rtl/dmem_lane_mux.sv
// Combinational lane logic: extracts and extends a load from a stored word, and
// merges right-aligned store data into that word at the addressed lane.
module dmem_lane_mux
  import dmem_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  offset,
  input  logic [3:0]  sign_mask,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_in[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word_in[31:16] : word_in[15:0];
    case (sign_mask[2:0])
      SM_BYTE: load_value = {{24{sign_mask[3] & byte_sel[7]}}, byte_sel};
      SM_HALF: load_value = {{16{sign_mask[3] & half_sel[15]}}, half_sel};
      default: load_value = word_in;
    endcase
  end

  // Untouched lanes of a sub-word store keep the previously read word.
  always_comb begin
    store_word = word_in;
    case (sign_mask[2:0])
      SM_BYTE: store_word[{offset, 3'b000} +: 8] = store_data[7:0];
      SM_HALF: begin
        if (offset[1]) store_word[31:16] = store_data[15:0];
        else           store_word[15:0]  = store_data[15:0];
      end
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/data_mem_param.sv
// Parametrised RV32I data memory with LED register and fault reporting.
// Optional DMEM_LINE_HIT_EN adds a last-word register so repeat loads skip the RAM read cycle.
module data_mem_param
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter logic [31:0] LED_ADDR    = 32'h0000_2000,
  parameter int          LED_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      write_data,
  input  logic             memwrite,
  input  logic             memread,
  input  logic [3:0]       sign_mask,
  output logic [31:0]      read_data,
  output logic [LED_W-1:0] led,
  output logic             clk_stall,
  output logic             fault,
  output logic [31:0]      fault_addr
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t state;

  logic [31:0] addr_buf;
  logic [31:0] wdata_buf;
  logic        rd_buf;
  logic [3:0]  sm_buf;
  logic [31:0] led_reg;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_q;
  logic [31:0] word_buf;
  logic [31:0] load_value;
  logic [31:0] store_word;

  logic             buf_fault;
  logic             buf_led;
  logic [IDX_W-1:0] buf_idx;

  function automatic logic in_ram(input logic [31:0] a);
    return ((a - MEM_BASE) >> (IDX_W + 2)) == 32'd0;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - MEM_BASE) >> 2);
  endfunction

  function automatic logic access_fault(input logic [31:0] a, input logic [2:0] w);
    logic misaligned;
    misaligned = ((w == SM_HALF) && a[0]) || ((w == SM_WORD) && (a[1:0] != 2'b00));
    return misaligned || !((a == LED_ADDR) || in_ram(a));
  endfunction

  assign buf_fault = access_fault(addr_buf, sm_buf[2:0]);
  assign buf_led   = (addr_buf == LED_ADDR);
  assign buf_idx   = word_idx(addr_buf);
  assign led       = led_reg[LED_W-1:0];

`ifdef DMEM_LINE_HIT_EN
  logic             line_valid;
  logic [IDX_W-1:0] line_idx;
  logic [31:0]      line_data;
  logic             hit_buf;
  logic             hit_in;

  // Decided on the live inputs because a hit skips the buffering cycle.
  assign hit_in = memread && line_valid && (addr != LED_ADDR) &&
                  !access_fault(addr, sign_mask[2:0]) && (word_idx(addr) == line_idx);
  assign word_buf = hit_buf ? line_data : ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_valid <= 1'b0;
      line_idx   <= '0;
      line_data  <= '0;
    end else if ((state == READ) || (state == WRITE)) begin
      if (buf_fault) begin
        line_valid <= 1'b0;
      end else if (!buf_led) begin
        line_valid <= 1'b1;
        line_idx   <= buf_idx;
        line_data  <= (state == WRITE) ? store_word : word_buf;
      end
    end
  end
`else
  assign word_buf = ram_q;
`endif

  // RAM contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (state == READ_BUFFER) begin
      ram_q <= mem[buf_idx];
    end
    if ((state == WRITE) && !buf_fault && !buf_led) begin
      mem[buf_idx] <= store_word;
    end
  end

  dmem_lane_mux u_lane_mux (
    .word_in    (word_buf),
    .offset     (addr_buf[1:0]),
    .sign_mask  (sm_buf),
    .store_data (wdata_buf),
    .load_value (load_value),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clk_stall  <= 1'b0;
      read_data  <= '0;
      led_reg    <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
      addr_buf   <= '0;
      wdata_buf  <= '0;
      rd_buf     <= 1'b0;
      sm_buf     <= '0;
`ifdef DMEM_LINE_HIT_EN
      hit_buf    <= 1'b0;
`endif
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          addr_buf  <= addr;
          wdata_buf <= write_data;
          rd_buf    <= memread;
          sm_buf    <= sign_mask;
`ifdef DMEM_LINE_HIT_EN
          hit_buf   <= 1'b0;
`endif
          if (memread || memwrite) begin
            clk_stall <= 1'b1;
`ifdef DMEM_LINE_HIT_EN
            if (hit_in) begin
              hit_buf <= 1'b1;
              state   <= READ;
            end else begin
              state   <= READ_BUFFER;
            end
`else
            state <= READ_BUFFER;
`endif
          end
        end
        READ_BUFFER: begin
          state <= rd_buf ? READ : WRITE;
        end
        READ: begin
          clk_stall <= 1'b0;
          state     <= IDLE;
          fault     <= buf_fault;
          if (buf_fault) begin
            read_data  <= '0;
            fault_addr <= addr_buf;
          end else if (buf_led) begin
            read_data <= led_reg;
          end else begin
            read_data <= load_value;
          end
        end
        WRITE: begin
          clk_stall <= 1'b0;
          state     <= IDLE;
          fault     <= buf_fault;
          if (buf_fault) begin
            read_data  <= '0;
            fault_addr <= addr_buf;
          end else if (buf_led) begin
            led_reg <= wdata_buf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_mem_param.md
Name: data_mem_param

Overview:
- Parametrised successor of the RV32I data memory: a word-organised block RAM with byte, halfword and word loads/stores, sign/zero extension and a memory-mapped LED register.
- Sits on the core's MEM stage and stalls the core via clk_stall while an access is in flight.
- New over the previous generation:
  - async active-low reset
  - configurable depth, base address and LED map
  - LED read-back
  - alignment/range fault reporting

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, minimum 4.
- MEM_BASE, 32'h0000_0000: byte address of word 0; must be DEPTH_WORDS*4 aligned.
- LED_ADDR, 32'h0000_2000: byte address of the LED register; word aligned, outside the RAM range.
- LED_W, 8: width of the led output, 1..32.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- addr  in  32  byte address, sampled in IDLE
- write_data  in  32  store data, right-aligned
- memwrite  in  1  store request
- memread  in  1  load request
- sign_mask  in  4  [3] sign-extend; [2:0] 001 byte, 011 half, 111 word
- read_data  out  32  load result, registered
- led  out  LED_W  led_reg[LED_W-1:0]
- clk_stall  out  1  high while an access is in flight
- fault  out  1  one-cycle pulse: the completing access faulted
- fault_addr  out  32  addr of the most recent faulting access

Behaviour:
Reset (rst_n low, async):
- state=IDLE; clk_stall=0; read_data=0; led_reg=0; fault=0; fault_addr=0.
- RAM contents are not reset.

States:
- IDLE: every cycle, latch addr, write_data, memread, memwrite and sign_mask into buffers.
  - If memread|memwrite: go to READ_BUFFER, clk_stall<=1.
  - memread and memwrite both high: treat as a read; the write is ignored.
- READ_BUFFER: word_buf<=RAM[(addr_buf-MEM_BASE)>>2]; read has priority -> READ, else -> WRITE.
- READ: read_data<=extracted value; clk_stall<=0; -> IDLE.
- WRITE: RAM[idx]<=merged word; clk_stall<=0; -> IDLE.

Latency: request seen in IDLE at edge N; clk_stall high for edges N+1..N+2; read_data valid after edge N+2.

Loads:
- byte lane = addr[1:0]; half lane = addr[1].
- sign_mask[3]=1 sign-extends from bit 7/15, else zero-extends.

Stores:
- byte/half merged into word_buf at the lane; the other bytes are preserved.
- word replaces the whole word.

LED register:
- Decode is addr_buf==LED_ADDR; no RAM access.
- Store: led_reg<=write_data.
- Load: read_data<=led_reg, full 32 bits, ignoring extension.
- Same state path and timing as RAM.

Faults, evaluated on buffered values:
- half with addr[0]=1; word with addr[1:0]!=0
- address neither LED_ADDR nor within [MEM_BASE, MEM_BASE+DEPTH_WORDS*4)
- On fault: no RAM/LED update, read_data<=0, fault pulses high for 1 cycle coincident with the READ/WRITE edge, fault_addr<=addr_buf.
- Timing is unchanged.

Reset mid-access: returns to IDLE at once; a pending write is discarded and the RAM is unchanged.

A new request is accepted only in IDLE. Requests asserted while clk_stall=1 are ignored; the core holds them.

Optional Feature:
- Macro DMEM_LINE_HIT_EN.
- With it defined: a last-word register (valid bit, word index, data) is added.
  - Valid is cleared on reset and on any fault.
  - It is updated on every RAM read and write.
  - A non-faulting load whose word index matches a valid entry goes IDLE->READ directly: 1 stall cycle, data taken from the register.
  - A store to a matching word updates the register and the RAM.
- Without it: every access takes 2 stall cycles.
- Functional results are identical in both builds.

Decomposition:
- Package dmem_pkg holds:
  - state encoding: IDLE, READ_BUFFER, READ, WRITE
  - sign_mask width constants: SM_BYTE=3'b001, SM_HALF=3'b011, SM_WORD=3'b111
- One sub-module, dmem_lane_mux: purely combinational load-extract and store-merge from (word_buf, byte offset, sign_mask, write data).
- The FSM, LED register, fault decode and RAM stay in the top level.

Test Plan:
- Store word 32'hDEADBEEF @0x10, load word @0x10 -> read_data=32'hDEADBEEF; clk_stall high exactly 2 cycles per access.
- Store byte 8'h80 @0x13, then signed byte load @0x13 -> 32'hFFFFFF80; unsigned -> 32'h00000080; word @0x10 -> 32'h80ADBEEF.
- Store word 32'h0000_00A5 @LED_ADDR -> led=8'hA5; load word @LED_ADDR -> 32'h000000A5.
- Halfword load @0x11, then word store @(MEM_BASE+DEPTH_WORDS*4) -> fault pulse each, read_data=0, fault_addr=0x11 then the out-of-range address, RAM unchanged.
- rst_n low during READ_BUFFER of a store to @0x20 -> clk_stall=0, state IDLE, RAM@0x20 keeps its old value, led=0.
- With DMEM_LINE_HIT_EN: load @0x10 twice -> first load 2 stall cycles, second 1, same data; after a store to @0x12, reload reflects the new halfword.
